prio_encoder_reg: RTL

- Parametrised, registered N-to-log2(N) priority encoder. Successor to the team's fixed 4-to-2 combinational encoder.
- Samples a one-hot or multi-hot request vector through a valid/ready handshake.
- Produces a registered index with "any" and "multi-hot" flags, and keeps a saturating count of multi-hot (illegal one-hot) samples.
- Sits between interrupt/request sources and downstream control logic that needs a binary index.

---
 rtl/prio_encoder_pkg.sv | 26 ++
 rtl/prio_encoder_reg_if.sv | 27 ++
 rtl/prio_search.sv | 31 +++
 rtl/prio_encoder_reg.sv | 93 +++++++++
 4 files changed

// File: rtl/prio_encoder_pkg.sv
// Shared helpers for the registered priority encoder: index width, popcount
// and the round-robin pointer reset value.
package prio_encoder_pkg;

  // Widest request vector popcount() accepts; narrower vectors are zero-extended.
  localparam int POP_MAX_N = 256;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_N-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX_N; i++) begin
      cnt += {31'd0, v[i]};
    end
    return cnt;
  endfunction

  // Pointer resets to the top index so the first round-robin search begins at 0.
  function automatic int rr_ptr_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/prio_encoder_reg_if.sv
// Request/result handshake bundle for prio_encoder_reg.
// master = request source and result sink, slave = the encoder.
interface prio_encoder_reg_if #(
  parameter int N = 4
);
  localparam int IDX_W = prio_encoder_pkg::idx_width(N);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_any;
  logic             out_multi;

  modport master (
    output in_valid, req, out_ready,
    input  in_ready, out_valid, out_idx, out_any, out_multi
  );

  modport slave (
    input  in_valid, req, out_ready,
    output in_ready, out_valid, out_idx, out_any, out_multi
  );

endinterface

// File: rtl/prio_search.sv
// Combinational circular first-set-bit search over the request vector.
// mode=0: descending from start inclusive; mode=1: ascending from start+1.
module prio_search
  import prio_encoder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   start,
  input  logic                      mode,
  output logic [idx_width(N)-1:0]   idx,
  output logic                      any
);

  localparam int IDX_W = idx_width(N);

  always_comb begin
    int pos;
    pos = 0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = mode ? ((int'(start) + 1 + k) % N) : ((int'(start) - k + N) % N);
      if (!any && req[pos[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_encoder_reg.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshake and a
// saturating multi-hot counter. Define PRIO_ENCODER_RR_EN for round-robin search.
module prio_encoder_reg
  import prio_encoder_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  prio_encoder_reg_if.slave  bus,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int IDX_W = idx_width(N);

  logic [IDX_W-1:0] start;
  logic             mode;
  logic [IDX_W-1:0] srch_idx;
  logic             srch_any;
  logic             multi;
  logic             accept;

  logic             vld_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             any_p1;
  logic             multi_p1;

  prio_search #(.N(N)) u_search (
    .req   (bus.req),
    .start (start),
    .mode  (mode),
    .idx   (srch_idx),
    .any   (srch_any)
  );

`ifdef PRIO_ENCODER_RR_EN
  logic [IDX_W-1:0] ptr;

  // Pointer only moves on a non-empty accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(rr_ptr_rst(N));
    end else if (accept && srch_any) begin
      ptr <= srch_idx;
    end
  end

  assign start = ptr;
  assign mode  = 1'b1;
`else
  assign start = IDX_W'(N - 1);
  assign mode  = 1'b0;
`endif

  assign multi        = (popcount(POP_MAX_N'(bus.req)) >= 2);
  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // ---- stage p1: result register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      idx_p1   <= '0;
      any_p1   <= 1'b0;
      multi_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      idx_p1   <= srch_idx;
      any_p1   <= srch_any;
      multi_p1 <= multi;
    end else if (bus.out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (accept && multi && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_idx   = idx_p1;
  assign bus.out_any   = any_p1;
  assign bus.out_multi = multi_p1;

endmodule
